// File: rtl/sfr_bus_arbiter_if.sv
// Requester-side port bundle of the SFR bus arbiter (one instance per requester).
// master: the requester (core or peripheral unit) drives request fields, receives completion.
// slave : the arbiter receives request fields and drives ack/err/rdata/rbit.
//   req     level request, held until ack
//   we      1 = write, 0 = read
//   is_bit  1 = bit access, 0 = byte access
//   addr    byte address, or direct bit address in bit mode
//   wdata   byte write data; wbit = bit write data
//   ack     one-cycle completion pulse; err qualifies it (address below SFR base)
//   rdata   read byte, valid in the ack cycle; rbit = read bit, valid in the ack cycle
interface sfr_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic          is_bit;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wbit;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;
  logic          rbit;

  modport master (
    output req, we, is_bit, addr, wdata, wbit,
    input  ack, err, rdata, rbit
  );

  modport slave (
    input  req, we, is_bit, addr, wdata, wbit,
    output ack, err, rdata, rbit
  );
endinterface

// File: rtl/sfr_bus_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the SFR bank (A = core, B = peripheral/irq unit).
// Latency from the request-sampling edge: write/error ack at +1 cycle, read ack at +2 cycles.
// Backpressure: requests are levels held until ack; the FSM always returns through IDLE, so
//   one write per 2 cycles and one read per 3 cycles at most.
// Ports: clk, reset (async, active-low); port_a/port_b requester bundles (slave side);
//   sfr_addr/sfr_en/sfr_oe/sfr_Bb/sfr_pos/sfr_din/sfr_bin drive the SFR register file,
//   sfr_dout/sfr_bout are its registered outputs.
module sfr_bus_arbiter #(
  parameter int          AW       = 8,
  parameter int          DW       = 8,
  parameter int unsigned SFR_BASE = 'h80
) (
  input  logic          clk,
  input  logic          reset,
  sfr_bus_arbiter_if.slave port_a,
  sfr_bus_arbiter_if.slave port_b,
  output logic [AW-1:0] sfr_addr,
  output logic          sfr_en,
  output logic          sfr_oe,
  output logic          sfr_Bb,
  output logic [DW-1:0] sfr_pos,
  output logic [DW-1:0] sfr_din,
  output logic          sfr_bin,
  input  logic [DW-1:0] sfr_dout,
  input  logic          sfr_bout
);

  localparam logic [AW-1:0] BASE    = AW'(SFR_BASE);
  localparam logic [DW-1:0] POS_ONE = DW'(1);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, ERR} state_t;

  state_t        state;
  logic          gnt_b;    // granted port of the transaction in flight (1 = B)
  logic          last_b;   // port granted most recently (1 = B)
  logic          lat_bit;  // latched access mode, steers read data in CAP
  logic          ack_a, ack_b, err_a, err_b;

  logic          pick_b;
  logic          any_req;
  logic          sel_we, sel_bit, sel_wbit;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // B wins only when A is idle or when A was served last.
  assign any_req = port_a.req | port_b.req;
  assign pick_b  = port_b.req & (~port_a.req | ~last_b);

  always_comb begin
    sel_we    = port_a.we;
    sel_bit   = port_a.is_bit;
    sel_addr  = port_a.addr;
    sel_wdata = port_a.wdata;
    sel_wbit  = port_a.wbit;
    if (pick_b) begin
      sel_we    = port_b.we;
      sel_bit   = port_b.is_bit;
      sel_addr  = port_b.addr;
      sel_wdata = port_b.wdata;
      sel_wbit  = port_b.wbit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt_b    <= 1'b0;
      last_b   <= 1'b1;
      lat_bit  <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      sfr_en   <= 1'b0;
      sfr_oe   <= 1'b0;
      sfr_Bb   <= 1'b1;
      sfr_addr <= '0;
      sfr_pos  <= '0;
      sfr_din  <= '0;
      sfr_bin  <= 1'b0;
    end else begin
      // Strobes and completion flags are single-cycle pulses by default.
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      err_a  <= 1'b0;
      err_b  <= 1'b0;
      sfr_en <= 1'b0;
      sfr_oe <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_b   <= pick_b;
            last_b  <= pick_b;
            lat_bit <= sel_bit;
            sfr_din <= sel_wdata;
            sfr_bin <= sel_wbit;
            // Bit addresses select the byte SFR at the 8-aligned base plus a one-hot lane.
            if (sel_bit) begin
              sfr_Bb   <= 1'b0;
              sfr_addr <= {sel_addr[AW-1:3], 3'b000};
              sfr_pos  <= POS_ONE << sel_addr[2:0];
            end else begin
              sfr_Bb   <= 1'b1;
              sfr_addr <= sel_addr;
              sfr_pos  <= '0;
            end
            if (sel_addr < BASE) begin
              state <= ERR;
              ack_a <= ~pick_b;
              ack_b <= pick_b;
              err_a <= ~pick_b;
              err_b <= pick_b;
            end else if (sel_we) begin
              state  <= WR;
              sfr_en <= 1'b1;
              ack_a  <= ~pick_b;
              ack_b  <= pick_b;
            end else begin
              state  <= RD;
              sfr_oe <= 1'b1;
            end
          end
        end
        RD: begin
          // SFR file registers its outputs on this edge; they are valid during CAP.
          state <= CAP;
          ack_a <= ~gnt_b;
          ack_b <= gnt_b;
        end
        WR, CAP, ERR: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  assign port_a.ack   = ack_a;
  assign port_b.ack   = ack_b;
  assign port_a.err   = err_a;
  assign port_b.err   = err_b;
  // Read data is a pass-through of the registered SFR outputs, gated to the ack cycle.
  assign port_a.rdata = (state == CAP && !gnt_b && !lat_bit) ? sfr_dout : '0;
  assign port_b.rdata = (state == CAP &&  gnt_b && !lat_bit) ? sfr_dout : '0;
  assign port_a.rbit  = (state == CAP && !gnt_b &&  lat_bit) ? sfr_bout : 1'b0;
  assign port_b.rbit  = (state == CAP &&  gnt_b &&  lat_bit) ? sfr_bout : 1'b0;

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
module tb_sfr_bus_arbiter;

  typedef struct {
    bit         port;   // 1 = B
    bit         err;
    logic [7:0] rdata;
    bit         rbit;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sfr_addr, sfr_pos, sfr_din;
  logic       sfr_en, sfr_oe, sfr_Bb, sfr_bin;
  logic [7:0] sfr_dout = 8'h00;
  logic       sfr_bout = 1'b0;

  logic [7:0] mem    [256] = '{default: 8'h00};
  logic [7:0] shadow [256] = '{default: 8'h00};

  exp_t exp_q[$];
  exp_t mon_e;
  logic       got_err, got_rbit, oth_err, oth_rbit;
  logic [7:0] got_rdata, oth_rdata;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sfr_bus_arbiter_if #(.AW(8), .DW(8)) ia ();
  sfr_bus_arbiter_if #(.AW(8), .DW(8)) ib ();

  sfr_bus_arbiter #(.AW(8), .DW(8), .SFR_BASE('h80)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .port_a   (ia.slave),
    .port_b   (ib.slave),
    .sfr_addr (sfr_addr),
    .sfr_en   (sfr_en),
    .sfr_oe   (sfr_oe),
    .sfr_Bb   (sfr_Bb),
    .sfr_pos  (sfr_pos),
    .sfr_din  (sfr_din),
    .sfr_bin  (sfr_bin),
    .sfr_dout (sfr_dout),
    .sfr_bout (sfr_bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SFR register file stand-in with registered outputs.
  always @(posedge clk) begin
    if (sfr_en) begin
      if (sfr_Bb) mem[sfr_addr] <= sfr_din;
      else        mem[sfr_addr] <= (mem[sfr_addr] & ~sfr_pos) | (sfr_bin ? sfr_pos : 8'h00);
    end
    if (sfr_oe) begin
      sfr_dout <= mem[sfr_addr];
      sfr_bout <= |(mem[sfr_addr] & sfr_pos);
    end
  end

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.ack || ib.ack) begin
        checks++;
        if (ia.ack && ib.ack) begin
          errors++; $display("FAIL ack_overlap cyc=%0d ack_a=%b ack_b=%b required one-hot", cyc, ia.ack, ib.ack);
        end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack cyc=%0d ack_a=%b ack_b=%b required none", cyc, ia.ack, ib.ack);
        end else begin
          mon_e     = exp_q.pop_front();
          got_err   = mon_e.port ? ib.err   : ia.err;
          got_rdata = mon_e.port ? ib.rdata : ia.rdata;
          got_rbit  = mon_e.port ? ib.rbit  : ia.rbit;
          oth_err   = mon_e.port ? ia.err   : ib.err;
          oth_rdata = mon_e.port ? ia.rdata : ib.rdata;
          oth_rbit  = mon_e.port ? ia.rbit  : ib.rbit;
          checks++;
          if (ib.ack !== mon_e.port || ia.ack !== !mon_e.port) begin
            errors++; $display("FAIL ack_port cyc=%0d got a=%b b=%b required b=%b", cyc, ia.ack, ib.ack, mon_e.port);
          end
          checks++;
          if (cyc !== mon_e.cyc) begin
            errors++; $display("FAIL ack_cycle got=%0d required=%0d", cyc, mon_e.cyc);
          end
          checks++;
          if (got_err !== mon_e.err) begin
            errors++; $display("FAIL ack_err cyc=%0d got=%b required=%b", cyc, got_err, mon_e.err);
          end
          checks++;
          if (got_rdata !== mon_e.rdata) begin
            errors++; $display("FAIL rdata cyc=%0d got=%h required=%h", cyc, got_rdata, mon_e.rdata);
          end
          checks++;
          if (got_rbit !== mon_e.rbit) begin
            errors++; $display("FAIL rbit cyc=%0d got=%b required=%b", cyc, got_rbit, mon_e.rbit);
          end
          checks++;
          if ({oth_err, oth_rdata, oth_rbit} !== 10'd0) begin
            errors++; $display("FAIL other_port_quiet cyc=%0d got err=%b rdata=%h rbit=%b required 0", cyc, oth_err, oth_rdata, oth_rbit);
          end
        end
      end else begin
        checks++;
        if ({ia.err, ib.err, ia.rdata, ib.rdata, ia.rbit, ib.rbit} !== 20'd0) begin
          errors++; $display("FAIL no_ack_outputs cyc=%0d got err=%b%b rdata=%h/%h rbit=%b%b required 0",
                             cyc, ia.err, ib.err, ia.rdata, ib.rdata, ia.rbit, ib.rbit);
        end
      end
    end
  end

  task automatic drv(input bit port, input bit rq, input bit we, input bit bt,
                     input logic [7:0] addr, input logic [7:0] wd, input bit wb);
    if (port) begin
      ib.req = rq; ib.we = we; ib.is_bit = bt; ib.addr = addr; ib.wdata = wd; ib.wbit = wb;
    end else begin
      ia.req = rq; ia.we = we; ia.is_bit = bt; ia.addr = addr; ia.wdata = wd; ia.wbit = wb;
    end
  endtask

  // Expected completion from a behavioural view of the SFR bank.
  task automatic predict(input bit port, input bit we, input bit bt, input logic [7:0] addr,
                         input logic [7:0] wd, input bit wb, input int at);
    exp_t       e;
    logic [7:0] ba;
    ba      = bt ? {addr[7:3], 3'b000} : addr;
    e.port  = port;
    e.cyc   = at;
    e.err   = (addr < 8'h80);
    e.rdata = 8'h00;
    e.rbit  = 1'b0;
    if (!e.err) begin
      if (we) begin
        if (bt) shadow[ba][addr[2:0]] = wb;
        else    shadow[ba] = wd;
      end else begin
        if (bt) e.rbit  = shadow[ba][addr[2:0]];
        else    e.rdata = shadow[ba];
      end
    end
    exp_q.push_back(e);
  endtask

  // Waits (bounded) until every expected ack has been seen; ends at negedge+1.
  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < budget);
  endtask

  task automatic idle_gap();
    drv(0, 0, 0, 0, 8'h00, 8'h00, 0);
    drv(1, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 8'h00, 8'h00, 0);
    drv(1, 0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 8'h00, 8'h00, 0);
    drv(1, 0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ia.ack, ib.ack, ia.err, ib.err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ack_err got=%b required=0000", {ia.ack, ib.ack, ia.err, ib.err});
    end
    checks++;
    if ({sfr_en, sfr_oe, sfr_Bb, sfr_bin} !== 4'b0010) begin
      errors++; $display("FAIL reset_strobes got en/oe/Bb/bin=%b required=0010", {sfr_en, sfr_oe, sfr_Bb, sfr_bin});
    end
    checks++;
    if ({sfr_addr, sfr_pos, sfr_din, ia.rdata, ib.rdata, ia.rbit, ib.rbit} !== 42'd0) begin
      errors++; $display("FAIL reset_buses got addr=%h pos=%h din=%h rdata=%h/%h rbit=%b%b required 0",
                         sfr_addr, sfr_pos, sfr_din, ia.rdata, ib.rdata, ia.rbit, ib.rbit);
    end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_byte_rw();
    int c = cyc;
    drv(0, 1, 1, 0, 8'hA8, 8'h5C, 0);
    predict(0, 1, 0, 8'hA8, 8'h5C, 0, c + 1);
    @(posedge clk); #1;
    checks++;
    if (sfr_en !== 1'b1 || sfr_oe !== 1'b0) begin
      errors++; $display("FAIL bytewr_strobe got en=%b oe=%b required en=1 oe=0", sfr_en, sfr_oe);
    end
    checks++;
    if (sfr_addr !== 8'hA8 || sfr_Bb !== 1'b1 || sfr_din !== 8'h5C || sfr_pos !== 8'h00) begin
      errors++; $display("FAIL bytewr_bus got addr=%h Bb=%b din=%h pos=%h required A8 1 5C 00", sfr_addr, sfr_Bb, sfr_din, sfr_pos);
    end
    wait_done(8);
    idle_gap();
    c = cyc;
    drv(0, 1, 0, 0, 8'hA8, 8'h00, 0);
    predict(0, 0, 0, 8'hA8, 8'h00, 0, c + 2);
    @(posedge clk); #1;
    checks++;
    if (sfr_oe !== 1'b1 || sfr_en !== 1'b0 || sfr_addr !== 8'hA8) begin
      errors++; $display("FAIL byterd_strobe got oe=%b en=%b addr=%h required 1 0 A8", sfr_oe, sfr_en, sfr_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (sfr_oe !== 1'b0) begin
      errors++; $display("FAIL byterd_cap_oe got=%b required=0", sfr_oe);
    end
    wait_done(8);
    idle_gap();
  endtask

  task automatic test_bit_rw();
    int c = cyc;
    drv(1, 1, 1, 1, 8'hD3, 8'hFF, 1);
    predict(1, 1, 1, 8'hD3, 8'hFF, 1, c + 1);
    @(posedge clk); #1;
    checks++;
    if (sfr_addr !== 8'hD0 || sfr_pos !== 8'h08 || sfr_Bb !== 1'b0 || sfr_bin !== 1'b1 || sfr_en !== 1'b1) begin
      errors++; $display("FAIL bitwr_bus got addr=%h pos=%h Bb=%b bin=%b en=%b required D0 08 0 1 1",
                         sfr_addr, sfr_pos, sfr_Bb, sfr_bin, sfr_en);
    end
    wait_done(8);
    idle_gap();
    c = cyc;
    drv(1, 1, 0, 1, 8'hD3, 8'h00, 0);
    predict(1, 0, 1, 8'hD3, 8'h00, 0, c + 2);
    wait_done(8);
    idle_gap();
    c = cyc;
    drv(1, 1, 0, 1, 8'hD2, 8'h00, 0);
    predict(1, 0, 1, 8'hD2, 8'h00, 0, c + 2);
    wait_done(8);
    idle_gap();
    c = cyc;
    drv(0, 1, 0, 0, 8'hD0, 8'h00, 0);
    predict(0, 0, 0, 8'hD0, 8'h00, 0, c + 2);
    wait_done(8);
    idle_gap();
  endtask

  task automatic test_error();
    int c = cyc;
    drv(0, 1, 0, 0, 8'h30, 8'h00, 0);
    predict(0, 0, 0, 8'h30, 8'h00, 0, c + 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) drv(0, 0, 0, 0, 8'h00, 8'h00, 0);
      checks++;
      if (sfr_en !== 1'b0 || sfr_oe !== 1'b0) begin
        errors++; $display("FAIL err_no_strobe k=%0d got en=%b oe=%b required 0 0", k, sfr_en, sfr_oe);
      end
    end
    wait_done(8);
    idle_gap();
  endtask

  task automatic test_contention();
    int c;
    apply_reset();
    c = cyc;
    drv(0, 1, 1, 0, 8'h90, 8'h11, 0);
    drv(1, 1, 1, 0, 8'h98, 8'h22, 0);
    predict(0, 1, 0, 8'h90, 8'h11, 0, c + 1);
    predict(1, 1, 0, 8'h98, 8'h22, 0, c + 3);
    predict(0, 1, 0, 8'h90, 8'h11, 0, c + 5);
    predict(1, 1, 0, 8'h98, 8'h22, 0, c + 7);
    wait_done(20);
    idle_gap();
  endtask

  task automatic test_reset_mid_read();
    int c;
    drv(0, 1, 0, 0, 8'hA8, 8'h00, 0);
    @(posedge clk); #1;
    checks++;
    if (sfr_oe !== 1'b1) begin
      errors++; $display("FAIL midrd_in_rd got oe=%b required=1", sfr_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sfr_oe !== 1'b0 || ia.ack !== 1'b0) begin
      errors++; $display("FAIL midrd_async got oe=%b ack_a=%b required 0 0", sfr_oe, ia.ack);
    end
    drv(0, 0, 0, 0, 8'h00, 8'h00, 0);
    @(posedge clk); #1;
    checks++;
    if ({sfr_oe, sfr_en, ia.ack, ib.ack} !== 4'b0000) begin
      errors++; $display("FAIL midrd_after_edge got oe/en/ack_a/ack_b=%b required 0000", {sfr_oe, sfr_en, ia.ack, ib.ack});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    c = cyc;
    drv(0, 1, 1, 0, 8'hC0, 8'h33, 0);
    drv(1, 1, 1, 0, 8'hC8, 8'h44, 0);
    predict(0, 1, 0, 8'hC0, 8'h33, 0, c + 1);
    predict(1, 1, 0, 8'hC8, 8'h44, 0, c + 3);
    wait_done(12);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    int         c = cyc;
    logic [7:0] d = 8'h01;
    bit         exp_en;
    drv(0, 1, 1, 0, 8'hB0, d, 0);
    predict(0, 1, 0, 8'hB0, d, 0, c + 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp_en = (k % 2 == 1);
      checks++;
      if (sfr_en !== exp_en) begin
        errors++; $display("FAIL b2b_en k=%0d got=%b required=%b", k, sfr_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (sfr_din !== d) begin
          errors++; $display("FAIL b2b_din k=%0d got=%h required=%h", k, sfr_din, d);
        end
        if (k < 5) begin
          d = d + 8'h01;
          drv(0, 1, 1, 0, 8'hB0, d, 0);
          predict(0, 1, 0, 8'hB0, d, 0, c + k + 2);
        end else begin
          drv(0, 0, 0, 0, 8'h00, 8'h00, 0);
        end
      end
    end
    wait_done(8);
    @(negedge clk); #1;
    c = cyc;
    drv(0, 1, 0, 0, 8'hB0, 8'h00, 0);
    predict(0, 0, 0, 8'hB0, 8'h00, 0, c + 2);
    wait_done(8);
    idle_gap();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_rw();
    test_bit_rw();
    test_error();
    test_contention();
    test_reset_mid_read();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_acks got pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
